// File: rtl/alu_rr_arbiter_if.sv
// Request/ALU/response bundle between the issue stages, alu_rr_arbiter and the alu.
// Arbiter side uses modport slave; requesters, alu and benches use modport master.
`ifndef DSIZE
`define DSIZE 8
`endif

interface alu_rr_arbiter_if #(
   parameter int DW   = `DSIZE,
   parameter int OPW  = 3,
   parameter int IMMW = 4
);
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [DW-1:0]   req_a0;
   logic [DW-1:0]   req_a1;
   logic [DW-1:0]   req_b0;
   logic [DW-1:0]   req_b1;
   logic [OPW-1:0]  req_op0;
   logic [OPW-1:0]  req_op1;
   logic [IMMW-1:0] req_imm0;
   logic [IMMW-1:0] req_imm1;
   logic [DW-1:0]   alu_a;
   logic [DW-1:0]   alu_b;
   logic [OPW-1:0]  alu_op;
   logic [IMMW-1:0] alu_imm;
   logic [DW-1:0]   alu_out;
   logic [1:0]      rsp_valid;
   logic [1:0]      rsp_ready;
   logic [DW-1:0]   rsp_data;
   logic            busy;

   modport slave (
      input  req_valid, req_a0, req_a1, req_b0, req_b1,
             req_op0, req_op1, req_imm0, req_imm1, alu_out, rsp_ready,
      output req_ready, alu_a, alu_b, alu_op, alu_imm, rsp_valid, rsp_data, busy
   );

   modport master (
      output req_valid, req_a0, req_a1, req_b0, req_b1,
             req_op0, req_op1, req_imm0, req_imm1, alu_out, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_op, alu_imm, rsp_valid, rsp_data, busy
   );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational alu.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win a tie.
`ifndef DSIZE
`define DSIZE 8
`endif

module alu_rr_arbiter #(
   parameter int DW   = `DSIZE,
   parameter int OPW  = 3,
   parameter int IMMW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_rr_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]      state_q, state_d;
   logic            gnt_q, gnt_d;
   logic            last_grant_q, last_grant_d;
   logic [DW-1:0]   alu_a_q, alu_a_d;
   logic [DW-1:0]   alu_b_q, alu_b_d;
   logic [OPW-1:0]  alu_op_q, alu_op_d;
   logic [IMMW-1:0] alu_imm_q, alu_imm_d;
   logic [DW-1:0]   rsp_data_q, rsp_data_d;
   logic [1:0]      rsp_valid_q, rsp_valid_d;

   logic            win;
   logic [1:0]      req_ready;
   logic [DW-1:0]   a_arr   [2];
   logic [DW-1:0]   b_arr   [2];
   logic [OPW-1:0]  op_arr  [2];
   logic [IMMW-1:0] imm_arr [2];

   assign a_arr[0]   = bus.req_a0;
   assign a_arr[1]   = bus.req_a1;
   assign b_arr[0]   = bus.req_b0;
   assign b_arr[1]   = bus.req_b1;
   assign op_arr[0]  = bus.req_op0;
   assign op_arr[1]  = bus.req_op1;
   assign imm_arr[0] = bus.req_imm0;
   assign imm_arr[1] = bus.req_imm1;

   // A lone requester always wins; a tie goes to whoever did not win last.
   always_comb begin
      win = bus.req_valid[1];
      if (&bus.req_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         win = 1'b0;
`else
         win = ~last_grant_q;
`endif
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_ready
         assign req_ready[gi] = (state_q == IDLE) && bus.req_valid[gi] && (win == 1'(gi));
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      last_grant_d = last_grant_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      alu_imm_d    = alu_imm_q;
      rsp_data_d   = rsp_data_q;
      rsp_valid_d  = rsp_valid_q;
      case (state_q)
         IDLE: begin
            if (|(bus.req_valid & req_ready)) begin
               alu_a_d      = a_arr[win];
               alu_b_d      = b_arr[win];
               alu_op_d     = op_arr[win];
               alu_imm_d    = imm_arr[win];
               gnt_d        = win;
               last_grant_d = win;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            // Operands have been stable at the alu for a full cycle by now.
            rsp_data_d  = bus.alu_out;
            rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
            state_d     = RESP;
         end
         RESP: begin
            if (bus.rsp_ready[gnt_q]) begin
               rsp_valid_d = 2'b00;
               state_d     = IDLE;
            end
         end
         default: begin
            rsp_valid_d = 2'b00;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         gnt_q        <= 1'b0;
         last_grant_q <= 1'b1;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         alu_imm_q    <= '0;
         rsp_data_q   <= '0;
         rsp_valid_q  <= 2'b00;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         alu_imm_q    <= alu_imm_d;
         rsp_data_q   <= rsp_data_d;
         rsp_valid_q  <= rsp_valid_d;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_op    = alu_op_q;
   assign bus.alu_imm   = alu_imm_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a small behavioural alu on the interface.
// Expected grant order follows ALU_ARB_FIXED_PRIO_EN when it is defined.
`timescale 1ns/1ps

module tb_alu_rr_arbiter;
   localparam int DW = 8;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   alu_rr_arbiter_if #(.DW(DW), .OPW(3), .IMMW(4)) bus ();

   alu_rr_arbiter #(.DW(DW), .OPW(3), .IMMW(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference alu: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 a+imm, 6 a<<imm, 7 not a.
   always_comb begin
      case (bus.alu_op)
         3'd0:    bus.alu_out = bus.alu_a + bus.alu_b;
         3'd1:    bus.alu_out = bus.alu_a - bus.alu_b;
         3'd2:    bus.alu_out = bus.alu_a & bus.alu_b;
         3'd3:    bus.alu_out = bus.alu_a | bus.alu_b;
         3'd4:    bus.alu_out = bus.alu_a ^ bus.alu_b;
         3'd5:    bus.alu_out = bus.alu_a + {4'd0, bus.alu_imm};
         3'd6:    bus.alu_out = bus.alu_a << bus.alu_imm[2:0];
         default: bus.alu_out = ~bus.alu_a;
      endcase
   end

   task automatic do_reset;
      rst_n = 1'b0;
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic set_req0(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic [3:0] imm);
      bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op; bus.req_imm0 = imm;
   endtask

   task automatic set_req1(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic [3:0] imm);
      bus.req_a1 = a; bus.req_b1 = b; bus.req_op1 = op; bus.req_imm1 = imm;
   endtask

   task automatic test_reset;
      do_reset();
      #1;
      checks++;
      if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", bus.rsp_valid); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      checks++;
      if (bus.alu_a !== 8'h00 || bus.alu_op !== 3'd0) begin errors++; $display("FAIL reset_alu got a=%h op=%0d want 0", bus.alu_a, bus.alu_op); end
      checks++;
      if (bus.rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h want 00", bus.rsp_data); end
      checks++;
      if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", bus.req_ready); end
      $display("reset: released, idle");
   endtask

   task automatic test_single_op;
      @(negedge clk);
      set_req0(8'd5, 8'd3, 3'd0, 4'd0);
      bus.rsp_ready = 2'b01;
      bus.req_valid = 2'b01;
      #1;
      checks++;
      if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 2'b00;
      checks++;
      if (bus.busy !== 1'b1 || bus.alu_a !== 8'd5 || bus.alu_b !== 8'd3) begin
         errors++; $display("FAIL single_exec got busy=%b a=%h b=%h want 1 05 03", bus.busy, bus.alu_a, bus.alu_b);
      end
      checks++;
      if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL single_early_rsp got %b want 00", bus.rsp_valid); end
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 8'd8) begin
         errors++; $display("FAIL single_rsp got valid=%b data=%h want 01 08", bus.rsp_valid, bus.rsp_data);
      end
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL single_done got valid=%b busy=%b want 00 0", bus.rsp_valid, bus.busy);
      end
      checks++;
      if (bus.rsp_data !== 8'd8 || bus.alu_a !== 8'd5) begin
         errors++; $display("FAIL single_hold got data=%h a=%h want 08 05", bus.rsp_data, bus.alu_a);
      end
      $display("single: req0 5+3 -> %0d", bus.rsp_data);
   endtask

   task automatic test_round_robin;
      int got;
      int exp_g;
      logic [7:0] exp_d;
      do_reset();
      set_req0(8'd10, 8'd4, 3'd1, 4'd0);     // 10-4 = 0x06
      set_req1(8'h0F, 8'h3C, 3'd2, 4'd0);    // 0x0F & 0x3C = 0x0C
      bus.rsp_ready = 2'b11;
      bus.req_valid = 2'b11;
      got = 0;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
         @(negedge clk);
         if (bus.rsp_valid !== 2'b00) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = got % 2;
`endif
            exp_d = (exp_g == 1) ? 8'h0C : 8'h06;
            checks++;
            if (bus.rsp_valid !== ((exp_g == 1) ? 2'b10 : 2'b01)) begin
               errors++; $display("FAIL rr_grant_%0d got %b want req%0d", got, bus.rsp_valid, exp_g);
            end
            checks++;
            if (bus.rsp_data !== exp_d) begin
               errors++; $display("FAIL rr_data_%0d got %h want %h", got, bus.rsp_data, exp_d);
            end
            $display("rr: response %0d valid=%b data=%h", got, bus.rsp_valid, bus.rsp_data);
            got++;
         end
      end
      bus.req_valid = 2'b00;
      checks++;
      if (got != 4) begin errors++; $display("FAIL rr_timeout got %0d responses want 4", got); end
      for (int cyc = 0; cyc < 10 && bus.busy !== 1'b0; cyc++) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_drain got busy=%b want 0", bus.busy); end
   endtask

   task automatic test_backpressure;
      @(negedge clk);
      set_req0(8'h20, 8'h00, 3'd5, 4'd3);    // 0x20 + 3 = 0x23
      set_req1(8'h01, 8'h01, 3'd0, 4'd0);
      bus.rsp_ready = 2'b10;                 // ready on the wrong port is ignored
      bus.req_valid = 2'b01;
      @(negedge clk);
      bus.req_valid = 2'b00;
      @(negedge clk);
      bus.req_valid = 2'b10;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 8'h23 || bus.req_ready !== 2'b00 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold_%0d got valid=%b data=%h ready=%b busy=%b want 01 23 00 1",
                     i, bus.rsp_valid, bus.rsp_data, bus.req_ready, bus.busy);
         end
         @(negedge clk);
      end
      bus.rsp_ready = 2'b01;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0 || bus.req_ready !== 2'b10) begin
         errors++; $display("FAIL bp_release got valid=%b busy=%b ready=%b want 00 0 10",
                            bus.rsp_valid, bus.busy, bus.req_ready);
      end
      bus.req_valid = 2'b00;
      #1;
      checks++;
      if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_drop_ready got %b want 00", bus.req_ready); end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.rsp_valid !== 2'b00) begin
         errors++; $display("FAIL bp_no_grant got busy=%b valid=%b want 0 00", bus.busy, bus.rsp_valid);
      end
      $display("backpressure: held 5 cycles, data=%h", bus.rsp_data);
   endtask

   task automatic test_drop_valid;
      @(negedge clk);
      set_req0(8'h0A, 8'h05, 3'd4, 4'd0);    // 0x0A ^ 0x05 = 0x0F
      bus.rsp_ready = 2'b00;
      bus.req_valid = 2'b01;
      @(negedge clk);
      bus.req_valid = 2'b10;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b01 || bus.rsp_data !== 8'h0F) begin
            errors++; $display("FAIL drop_busy_%0d got ready=%b valid=%b data=%h want 00 01 0f",
                               i, bus.req_ready, bus.rsp_valid, bus.rsp_data);
         end
      end
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b01;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL drop_idle_%0d got valid=%b busy=%b want 00 0", i, bus.rsp_valid, bus.busy);
         end
      end
      $display("drop_valid: req1 withdrew while busy, no grant");
   endtask

   task automatic test_back_to_back;
      int last_acc;
      int n_acc;
      @(negedge clk);
      set_req0(8'h03, 8'h00, 3'd6, 4'd2);    // 3 << 2 = 0x0C
      bus.rsp_ready = 2'b01;
      bus.req_valid = 2'b01;
      last_acc = -1;
      n_acc = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (bus.req_ready[0] === 1'b1) begin
            checks++;
            if (last_acc >= 0 && (i - last_acc) != 3) begin
               errors++; $display("FAIL b2b_interval got %0d want 3", i - last_acc);
            end
            last_acc = i;
            n_acc++;
         end
         @(negedge clk);
      end
      bus.req_valid = 2'b00;
      checks++;
      if (n_acc != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", n_acc); end
      for (int cyc = 0; cyc < 10 && bus.busy !== 1'b0; cyc++) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.rsp_data !== 8'h0C) begin
         errors++; $display("FAIL b2b_final got busy=%b data=%h want 0 0c", bus.busy, bus.rsp_data);
      end
      $display("back_to_back: %0d accepts in 12 cycles", n_acc);
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      set_req0(8'h77, 8'h08, 3'd3, 4'd0);    // 0x77 | 0x08 = 0x7F
      bus.rsp_ready = 2'b00;
      bus.req_valid = 2'b01;
      @(negedge clk);
      bus.req_valid = 2'b00;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 8'h7F) begin
         errors++; $display("FAIL mid_pre got valid=%b data=%h want 01 7f", bus.rsp_valid, bus.rsp_data);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0 || bus.alu_a !== 8'h00 || bus.rsp_data !== 8'h00) begin
         errors++; $display("FAIL mid_async got valid=%b busy=%b a=%h data=%h want 00 0 00 00",
                            bus.rsp_valid, bus.busy, bus.alu_a, bus.rsp_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL mid_after got valid=%b busy=%b want 00 0", bus.rsp_valid, bus.busy);
      end
      $display("reset_mid: in-flight op discarded");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b00;
      set_req0(8'h00, 8'h00, 3'd0, 4'd0);
      set_req1(8'h00, 8'h00, 3'd0, 4'd0);
      test_reset();
      test_single_op();
      test_round_robin();
      test_backpressure();
      test_drop_valid();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
